// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: per-stage write-enable / flush generator for an N-stage
// in-order pipeline. Handles memory freezes (whole-pipe or partial),
// redirects (including ones latched while frozen), load-use hazards,
// per-register valid tracking and saturating performance counters.
module pipe_stall_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int HAZ_STAGE  = 1,
   parameter int FREEZE_ALL = 1,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_STAGES-1:0] mem_stall_i,
   input  logic [NUM_STAGES-1:0] redirect_i,
   input  logic                  hazard_i,
   input  logic                  clr_cnt_i,
   output logic [NUM_STAGES-1:0] write_o,
   output logic [NUM_STAGES-1:0] flush_o,
   output logic [NUM_STAGES-1:0] valid_o,
   output logic                  pending_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o,
   output logic [CNT_W-1:0]      retire_cnt_o
);

   localparam int N  = NUM_STAGES;
   localparam int SW = $clog2(NUM_STAGES);

   logic             r_pending;
   logic [SW-1:0]    r_pend_stage;
   logic [N-1:1]     r_valid;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_retire_cnt;

   logic             w_freeze;
   logic [SW-1:0]    w_s_idx;
   logic [SW-1:0]    w_new_idx;
   logic [SW-1:0]    w_r_idx;
   logic             w_redir_any;
   logic             w_block;
   logic             w_apply;
   logic             w_haz;
   logic             w_retire;
   logic [N-1:0]     w_valid_full;
   logic             w_unused_redir0;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Redirect bit 0 would target the PC itself and has no meaning
   assign w_unused_redir0 = redirect_i[0];

   // Find the oldest (highest-index) stage waiting on memory
   always_comb begin
      w_freeze = 1'b0;
      w_s_idx  = '0;
      for (int i = 0; i < N; i++) begin
         if (mem_stall_i[i]) begin
            w_freeze = 1'b1;
            w_s_idx  = SW'(i);
         end
      end
   end

   // Find the oldest newly resolved redirect
   always_comb begin
      w_new_idx = '0;
      for (int i = 1; i < N; i++) begin
         if (redirect_i[i]) w_new_idx = SW'(i);
      end
   end

   // Effective redirect merges the new request with any latched one
   assign w_r_idx     = (r_pending && (r_pend_stage > w_new_idx)) ? r_pend_stage : w_new_idx;
   assign w_redir_any = (w_r_idx != '0);
   // A freeze blocks unless, in partial mode, the redirect is older than the stalled stage
   assign w_block     = w_freeze && ((FREEZE_ALL != 0) || (w_r_idx <= w_s_idx));
   assign w_apply     = !w_block && w_redir_any;
   // A redirect squashes the hazarding instruction, so the hazard only acts alone
   assign w_haz       = !w_block && !w_apply && hazard_i;

   // Per-stage write enables and bubble injection, in priority order
   always_comb begin
      write_o = '1;
      flush_o = '0;
      if (!rst_n) begin
         write_o = '0;
         flush_o = {{(N-1){1'b1}}, 1'b0};
      end else if (w_block) begin
         for (int k = 0; k < N; k++) begin
            write_o[k] = (FREEZE_ALL == 0) && (k > int'(w_s_idx));
            flush_o[k] = (FREEZE_ALL == 0) && (k == int'(w_s_idx) + 1);
         end
      end else if (w_apply) begin
         for (int k = 1; k < N; k++) flush_o[k] = (k <= int'(w_r_idx));
      end else if (w_haz) begin
         for (int k = 0; k < N; k++) begin
            write_o[k] = (k > HAZ_STAGE);
            flush_o[k] = (k == HAZ_STAGE + 1);
         end
      end
   end

   assign w_valid_full = {r_valid, 1'b1};
   assign valid_o      = w_valid_full;
   assign pending_o    = r_pending;
   assign w_retire     = valid_o[N-1] & write_o[N-1];
   assign stall_cnt_o  = r_stall_cnt;
   assign flush_cnt_o  = r_flush_cnt;
   assign retire_cnt_o = r_retire_cnt;

   // Latch redirects seen during a freeze; drop them once applied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending    <= 1'b0;
         r_pend_stage <= '0;
      end else if (w_block) begin
         r_pending    <= w_redir_any;
         r_pend_stage <= w_r_idx;
      end else if (w_apply) begin
         r_pending    <= 1'b0;
         r_pend_stage <= '0;
      end
   end

   // Valid bits follow the instruction flow; bubbles clear them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         for (int k = 1; k < N; k++) begin
            if (flush_o[k])      r_valid[k] <= 1'b0;
            else if (write_o[k]) r_valid[k] <= w_valid_full[k-1];
         end
      end
   end

   // Saturating performance counters with synchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_retire_cnt <= '0;
      end else if (clr_cnt_i) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         if (w_block || w_haz) r_stall_cnt  <= sat_inc(r_stall_cnt);
         if (w_apply)          r_flush_cnt  <= sat_inc(r_flush_cnt);
         if (w_retire)         r_retire_cnt <= sat_inc(r_retire_cnt);
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: drives a whole-pipe-freeze and a partial-freeze
// instance with the same stimulus and compares both against a reference
// model through an expected-value queue, plus directed scenario checks.
module tb_pipe_stall_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] mem_stall_i;
   logic [4:0] redirect_i;
   logic       hazard_i;
   logic       clr_cnt_i;

   logic [4:0] a_write, a_flush, a_valid;
   logic       a_pending;
   logic [7:0] a_stall_cnt, a_flush_cnt, a_retire_cnt;
   logic [4:0] b_write, b_flush, b_valid;
   logic       b_pending;
   logic [7:0] b_stall_cnt, b_flush_cnt, b_retire_cnt;

   int n_checks;
   int n_pass;

   pipe_stall_ctrl #(.NUM_STAGES(5), .HAZ_STAGE(1), .FREEZE_ALL(1), .CNT_W(8)) u_dut_fa1 (
      .clk(clk), .rst_n(rst_n), .mem_stall_i(mem_stall_i), .redirect_i(redirect_i),
      .hazard_i(hazard_i), .clr_cnt_i(clr_cnt_i), .write_o(a_write), .flush_o(a_flush),
      .valid_o(a_valid), .pending_o(a_pending), .stall_cnt_o(a_stall_cnt),
      .flush_cnt_o(a_flush_cnt), .retire_cnt_o(a_retire_cnt)
   );

   pipe_stall_ctrl #(.NUM_STAGES(5), .HAZ_STAGE(1), .FREEZE_ALL(0), .CNT_W(8)) u_dut_fa0 (
      .clk(clk), .rst_n(rst_n), .mem_stall_i(mem_stall_i), .redirect_i(redirect_i),
      .hazard_i(hazard_i), .clr_cnt_i(clr_cnt_i), .write_o(b_write), .flush_o(b_flush),
      .valid_o(b_valid), .pending_o(b_pending), .stall_cnt_o(b_stall_cnt),
      .flush_cnt_o(b_flush_cnt), .retire_cnt_o(b_retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state; index 0 = whole-pipe freeze, 1 = partial freeze
   logic [4:0] m_valid [2];
   logic       m_pend  [2];
   int         m_pst   [2];
   int         m_sc    [2];
   int         m_fc    [2];
   int         m_rc    [2];
   logic [4:0] m_wr    [2];
   logic [4:0] m_fl    [2];
   int         m_kind  [2];
   int         m_r     [2];

   typedef struct {
      string      tag;
      int         d;
      logic [4:0] wr;
      logic [4:0] fl;
      logic [4:0] vld;
      logic       pend;
      int         sc;
      int         fc;
      int         rc;
   } exp_t;

   exp_t sb[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 5'b00001;
         m_pend[d]  = 1'b0;
         m_pst[d]   = 0;
         m_sc[d]    = 0;
         m_fc[d]    = 0;
         m_rc[d]    = 0;
      end
   endtask

   // Expected write/flush for the current inputs; kind 1=freeze 2=redirect 3=hazard
   task automatic model_comb(input int d);
      int s, rn, r;
      logic fa;
      logic [4:0] wr, fl;
      fa = (d == 0);
      s = -1;
      for (int i = 0; i < 5; i++) if (mem_stall_i[i]) s = i;
      rn = 0;
      for (int i = 1; i < 5; i++) if (redirect_i[i]) rn = i;
      r = rn;
      if (m_pend[d] && (m_pst[d] > r)) r = m_pst[d];
      wr = 5'b11111;
      fl = 5'b00000;
      if (s >= 0 && (fa || r <= s)) begin
         m_kind[d] = 1;
         if (fa) wr = 5'b00000;
         else begin
            for (int k = 0; k < 5; k++) wr[k] = (k > s);
            if (s < 4) fl[s+1] = 1'b1;
         end
      end else if (r >= 1) begin
         m_kind[d] = 2;
         for (int k = 1; k <= r; k++) fl[k] = 1'b1;
      end else if (hazard_i) begin
         m_kind[d] = 3;
         wr = 5'b11100;
         fl = 5'b00100;
      end else begin
         m_kind[d] = 0;
      end
      m_r[d]  = r;
      m_wr[d] = wr;
      m_fl[d] = fl;
   endtask

   task automatic model_edge(input int d);
      logic [4:0] nv;
      nv = m_valid[d];
      for (int k = 1; k < 5; k++) begin
         if (m_fl[d][k])      nv[k] = 1'b0;
         else if (m_wr[d][k]) nv[k] = m_valid[d][k-1];
      end
      if (clr_cnt_i) begin
         m_sc[d] = 0;
         m_fc[d] = 0;
         m_rc[d] = 0;
      end else begin
         if ((m_kind[d] == 1 || m_kind[d] == 3) && m_sc[d] < 255) m_sc[d]++;
         if (m_kind[d] == 2 && m_fc[d] < 255) m_fc[d]++;
         if (m_valid[d][4] && m_wr[d][4] && m_rc[d] < 255) m_rc[d]++;
      end
      if (m_kind[d] == 1) begin
         m_pend[d] = (m_r[d] != 0);
         m_pst[d]  = m_r[d];
      end else if (m_kind[d] == 2) begin
         m_pend[d] = 1'b0;
         m_pst[d]  = 0;
      end
      m_valid[d] = nv;
   endtask

   // Push expectations for the driven inputs, then compare at the falling edge
   task automatic drive_eval(input string tag);
      exp_t e;
      logic [4:0] g_wr, g_fl, g_vld;
      logic g_pend;
      logic [7:0] g_sc, g_fc, g_rc;
      string nm;
      for (int d = 0; d < 2; d++) begin
         model_comb(d);
         e.tag  = tag;
         e.d    = d;
         e.wr   = m_wr[d];
         e.fl   = m_fl[d];
         e.vld  = m_valid[d];
         e.pend = m_pend[d];
         e.sc   = m_sc[d];
         e.fc   = m_fc[d];
         e.rc   = m_rc[d];
         sb.push_back(e);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.d == 0) begin
            g_wr = a_write; g_fl = a_flush; g_vld = a_valid; g_pend = a_pending;
            g_sc = a_stall_cnt; g_fc = a_flush_cnt; g_rc = a_retire_cnt;
            nm = {e.tag, "_fa1"};
         end else begin
            g_wr = b_write; g_fl = b_flush; g_vld = b_valid; g_pend = b_pending;
            g_sc = b_stall_cnt; g_fc = b_flush_cnt; g_rc = b_retire_cnt;
            nm = {e.tag, "_fa0"};
         end
         check_val({nm, "_write"},  32'(g_wr),   32'(e.wr));
         check_val({nm, "_flush"},  32'(g_fl),   32'(e.fl));
         check_val({nm, "_valid"},  32'(g_vld),  32'(e.vld));
         check_val({nm, "_pend"},   32'(g_pend), 32'(e.pend));
         check_val({nm, "_stcnt"},  32'(g_sc),   32'(e.sc));
         check_val({nm, "_flcnt"},  32'(g_fc),   32'(e.fc));
         check_val({nm, "_rtcnt"},  32'(g_rc),   32'(e.rc));
      end
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_eval("idle");
         clock_edge();
      end
   endtask

   logic [4:0] fill_tab [6];

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      mem_stall_i = '0;
      redirect_i  = '0;
      hazard_i    = 1'b0;
      clr_cnt_i   = 1'b0;
      fill_tab    = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd31};
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_write",  32'(a_write),     32'h0);
      check_val("rst_flush",  32'(a_flush),     32'h1e);
      check_val("rst_flush_fa0", 32'(b_flush),  32'h1e);
      check_val("rst_pend",   32'(a_pending),   32'h0);
      check_val("rst_valid",  32'(a_valid),     32'h1);
      check_val("rst_stcnt",  32'(a_stall_cnt), 32'h0);
      rst_n = 1'b1;

      // Free run: pipe fills, retirement starts
      for (int i = 0; i < 6; i++) begin
         drive_eval("fill");
         check_val("fill_valid", 32'(a_valid), 32'(fill_tab[i]));
         check_val("fill_write", 32'(a_write), 32'h1f);
         clock_edge();
      end
      check_val("fill_retire", 32'(a_retire_cnt), 32'd2);

      // Whole-pipe freeze with a redirect latched mid-freeze
      mem_stall_i = 5'b01000;
      drive_eval("fz1_c1");
      check_val("fz1_c1_write", 32'(a_write), 32'h0);
      clock_edge();
      redirect_i = 5'b00100;
      drive_eval("fz1_c2");
      check_val("fz1_c2_write", 32'(a_write), 32'h0);
      clock_edge();
      redirect_i = 5'b00000;
      drive_eval("fz1_c3");
      check_val("fz1_c3_write", 32'(a_write), 32'h0);
      check_val("fz1_c3_pend",  32'(a_pending), 32'h1);
      clock_edge();
      mem_stall_i = 5'b00000;
      drive_eval("fz1_apply");
      check_val("fz1_apply_flush", 32'(a_flush), 32'h06);
      clock_edge();
      check_val("fz1_pend_clr", 32'(a_pending),   32'h0);
      check_val("fz1_flcnt",    32'(a_flush_cnt), 32'd1);
      check_val("fz1_stcnt",    32'(a_stall_cnt), 32'd3);

      // Partial freeze, then an older redirect overriding it
      mem_stall_i = 5'b01000;
      drive_eval("fz0_stall");
      check_val("fz0_stall_write", 32'(b_write), 32'h10);
      check_val("fz0_stall_flush", 32'(b_flush), 32'h10);
      clock_edge();
      redirect_i = 5'b10000;
      drive_eval("fz0_redir");
      check_val("fz0_redir_write", 32'(b_write), 32'h1f);
      check_val("fz0_redir_flush", 32'(b_flush), 32'h1e);
      clock_edge();
      mem_stall_i = 5'b00000;
      redirect_i  = 5'b00000;
      idle(4);

      // Load-use hazard
      hazard_i = 1'b1;
      drive_eval("haz");
      check_val("haz_write", 32'(a_write), 32'h1c);
      check_val("haz_flush", 32'(a_flush), 32'h04);
      clock_edge();
      hazard_i = 1'b0;
      drive_eval("haz_next");
      check_val("haz_valid2", 32'(a_valid[2]), 32'h0);
      clock_edge();

      // Hazard and redirect together: redirect wins, no stall counted
      hazard_i   = 1'b1;
      redirect_i = 5'b00100;
      drive_eval("hazred");
      check_val("hazred_flush", 32'(a_flush), 32'h06);
      check_val("hazred_write", 32'(a_write), 32'h1f);
      clock_edge();
      hazard_i   = 1'b0;
      redirect_i = 5'b00000;
      check_val("hazred_stcnt", 32'(a_stall_cnt), 32'd6);

      // Stall counter saturation, then clear taking priority over increment
      mem_stall_i = 5'b00001;
      for (int i = 0; i < 260; i++) begin
         drive_eval("sat");
         clock_edge();
      end
      check_val("sat_stcnt_fa1", 32'(a_stall_cnt), 32'd255);
      check_val("sat_stcnt_fa0", 32'(b_stall_cnt), 32'd255);
      clr_cnt_i = 1'b1;
      drive_eval("clr");
      clock_edge();
      clr_cnt_i = 1'b0;
      check_val("clr_stcnt", 32'(a_stall_cnt), 32'd0);
      mem_stall_i = 5'b00000;
      idle(3);

      // Random mix of all inputs
      for (int i = 0; i < 80; i++) begin
         mem_stall_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
         redirect_i  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
         hazard_i    = ($urandom_range(0, 4) == 0);
         clr_cnt_i   = ($urandom_range(0, 19) == 0);
         drive_eval("rand");
         clock_edge();
      end
      hazard_i  = 1'b0;
      clr_cnt_i = 1'b0;

      // Reset asserted in the middle of a freeze with a redirect pending
      mem_stall_i = 5'b01000;
      redirect_i  = 5'b00100;
      drive_eval("rstfz");
      clock_edge();
      redirect_i = 5'b00000;
      check_val("rstfz_pend_set", 32'(a_pending), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("rstfz_pend_fa1", 32'(a_pending), 32'h0);
      check_val("rstfz_pend_fa0", 32'(b_pending), 32'h0);
      check_val("rstfz_write",    32'(a_write),   32'h0);
      check_val("rstfz_flush",    32'(a_flush),   32'h1e);
      model_reset();
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      mem_stall_i = 5'b00000;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Parametrised successor to the combinational stall/flush controller; drives per-stage write-enable and flush for an N-stage in-order pipeline.
- Adds the following behaviour:
  - partial (per-stage) freeze mode;
  - latching of redirects that arrive during a freeze;
  - per-register valid tracking;
  - saturating stall, flush and retire performance counters.
- Sits between the hazard/branch/cache units and the PC plus pipeline registers.

Parameters:
- NUM_STAGES, 5: pipeline depth N, minimum 3. Index 0 = PC; index k = pipeline register feeding stage k.
- HAZ_STAGE, 1: stage that detects load-use hazards. Legal range 1..N-2.
- FREEZE_ALL, 1: 1 = any memory stall freezes the whole pipe; 0 = freeze only the stalling stage and younger stages.
- CNT_W, 32: width of each performance counter.

Ports:
- clk, in, 1: clock; rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- mem_stall_i, in, N: bit s = stage s is waiting on memory (icache = bit 0, dcache = MEM stage).
- redirect_i, in, N: bit r = mispredict/jump resolved in stage r; bit 0 ignored.
- hazard_i, in, 1: load-use hazard detected at HAZ_STAGE.
- clr_cnt_i, in, 1: synchronous clear of all counters.
- write_o, out, N: bit 0 = PC write; bit k = register k write enable.
- flush_o, out, N: bit k = load a bubble into register k; bit 0 always 0.
- valid_o, out, N: bit k = register k holds a real instruction; bit 0 tied to 1.
- pending_o, out, 1: a latched redirect is waiting to be applied.
- stall_cnt_o, out, CNT_W: stall cycles.
- flush_cnt_o, out, CNT_W: applied redirects.
- retire_cnt_o, out, CNT_W: retired instructions.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pending state, valid_o[N-1:1] and all counters cleared to 0.
  - While reset is asserted: write_o=0, flush_o={N-1{1},0}, pending_o=0.
- write_o and flush_o are combinational from the inputs and the registered pending state. There is no added latency.
- Definitions used below:
  - s = highest set index of mem_stall_i ("freeze active" if any bit is set).
  - r = max(highest set index of redirect_i[N-1:1], pending stage). The pending stage counts only when pending_o=1.
- Priority per cycle, first match wins:
  - Freeze, FREEZE_ALL=1:
    - write_o=0, flush_o=0.
    - Any redirect_i is latched: pending stage <= max(pending stage, new r), pending_o <= 1.
  - Freeze, FREEZE_ALL=0, case r<=s:
    - write bits 0..s = 0, remaining bits = 1.
    - flush_o[s+1]=1 when s<N-1 (bubble behind the frozen stage).
    - The redirect is latched as in the FREEZE_ALL=1 case.
  - Freeze, FREEZE_ALL=0, case r>s:
    - Redirect is applied immediately; the freeze is ignored this cycle.
    - The stall source must cancel, since its instruction is squashed.
  - Redirect applied (r>=1, no blocking freeze):
    - write_o=all 1, flush_o bits 1..r = 1, others 0.
    - Pending cleared next edge. A new redirect_i in the same cycle is merged into r, not re-latched.
  - Hazard (hazard_i=1):
    - write bits 0..HAZ_STAGE = 0, remaining bits = 1.
    - flush_o[HAZ_STAGE+1]=1.
  - Otherwise: write_o=all 1, flush_o=0.
- Valid tracking, each edge, k=1..N-1:
  - flush_o[k] -> valid[k]<=0.
  - Else write_o[k] -> valid[k]<=valid[k-1].
  - Else hold.
- Counters, all saturating at 2^CNT_W-1:
  - stall_cnt +1 in any freeze or hazard cycle.
  - flush_cnt +1 in any cycle a redirect is applied.
  - retire_cnt +1 when valid_o[N-1]=1 and write_o[N-1]=1.
  - clr_cnt_i has priority over increment; the counter reads 0 next cycle.
- Boundary conditions:
  - Redirect and hazard in the same cycle: redirect wins; hazard is dropped, since the instruction is flushed.
  - Multiple redirect bits set: the oldest (highest index) wins.
  - Reset mid-freeze discards the pending redirect.
  - A redirect that is pending while hazard_i is asserted is applied first.

Test Plan (N=5, HAZ_STAGE=1, CNT_W=8):
- Reset release then 6 free-run cycles -> valid_o fills 1,3,7,15,31 (bit 0 included); retire_cnt_o=2 after the 6th edge; write_o=5'b11111 throughout.
- FREEZE_ALL=1: mem_stall_i[3] high 3 cycles with a 1-cycle redirect_i[2] pulse in the 2nd cycle -> write_o=0 for 3 cycles, pending_o=1. Then, in the cycle after the stall drops: flush_o=5'b00110, pending_o=0 next, flush_cnt_o=1, stall_cnt_o=3.
- FREEZE_ALL=0: mem_stall_i[3] only -> write_o=5'b10000, flush_o=5'b10000. Adding redirect_i[4] -> write_o=5'b11111, flush_o=5'b11110.
- hazard_i=1 for 1 cycle -> write_o=5'b11100, flush_o=5'b00100; valid_o[2]=0 next cycle.
- hazard_i with redirect_i[2] in the same cycle -> flush_o=5'b00110, write_o=5'b11111, stall_cnt_o unchanged.
- Force stall_cnt_o to 255 via 260 stall cycles -> holds 255. clr_cnt_i=1 -> 0 next cycle. Assert rst_n=0 mid-freeze with pending_o=1 -> pending_o=0 immediately.
